// File: rtl/cog_pkg.sv
// rtl/cog_pkg.sv - shared cog capture encodings, field positions and event helpers
package cog_pkg;

  localparam int CAP_PIN_LSB  = 0;
  localparam int CAP_PIN_MSB  = 4;
  localparam int CAP_MODE_LSB = 26;
  localparam int CAP_MODE_MSB = 28;

  localparam logic [31:0] CAP_SAT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    CAP_OFF   = 3'b000,
    CAP_HIGH  = 3'b001,
    CAP_LOW   = 3'b010,
    CAP_PER_R = 3'b011,
    CAP_PER_F = 3'b100
  } cap_mode_e;

  typedef enum logic {
    CAP_IDLE  = 1'b0,
    CAP_COUNT = 1'b1
  } cap_state_e;

  // Edge that begins a measurement in the given mode; off modes never start.
  function automatic logic cap_start(input logic [2:0] mode, input logic rise, input logic fall);
    case (mode)
      CAP_HIGH, CAP_PER_R: cap_start = rise;
      CAP_LOW, CAP_PER_F:  cap_start = fall;
      default:             cap_start = 1'b0;
    endcase
  endfunction

  // Edge that completes a measurement in the given mode.
  function automatic logic cap_end(input logic [2:0] mode, input logic rise, input logic fall);
    case (mode)
      CAP_HIGH, CAP_PER_F: cap_end = fall;
      CAP_LOW, CAP_PER_R:  cap_end = rise;
      default:             cap_end = 1'b0;
    endcase
  endfunction

  // Period modes restart counting on the end edge instead of returning to IDLE.
  function automatic logic cap_is_period(input logic [2:0] mode);
    cap_is_period = (mode == CAP_PER_R) || (mode == CAP_PER_F);
  endfunction

endpackage

// File: rtl/cog_cap_fifo.sv
// rtl/cog_cap_fifo.sv - capture result queue with flush, sticky overflow and full pass-through
module cog_cap_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop frees the slot the same-cycle push lands in, so full+pop+push loses nothing.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer and overflow bookkeeping; flush empties the queue and clears the sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  // Storage write; contents are don't-care while empty since dout is gated.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cog_cap.sv
// rtl/cog_cap.sv - per-cog input capture (pulse width / period), optional COG_CAP_GLITCH_EN majority filter
module cog_cap
  import cog_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_cog,
  input  logic        res,
  input  logic        setcap,
  input  logic [31:0] data,
  input  logic [31:0] pin_in,
  input  logic        rdcap,
  output logic [31:0] cap_data,
  output logic        cap_valid,
  output logic        cap_ovf,
  output logic        cap_busy
);

  logic [4:0]  cfg_pin;
  logic [2:0]  cfg_mode;
  logic        s0, s1, s2;
  logic        lvl;
  logic        rise, fall;
  logic        start_ev, end_ev;
  logic        push, pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic [31:0] cnt;
  cap_state_e  state;

  logic unused_data;
  assign unused_data = ^{data[31:29], data[25:5], fifo_full};

  // Two-flop synchronizer on the selected pin plus the history flop for edge detection.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s0 <= pin_in[cfg_pin];
      s1 <= s0;
      s2 <= lvl;
    end
  end

`ifdef COG_CAP_GLITCH_EN
  logic m0, m1, flt;

  // Registered 3-sample majority vote rejects single-cycle glitches after the synchronizer.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      m0  <= 1'b0;
      m1  <= 1'b0;
      flt <= 1'b0;
    end else begin
      m0  <= s1;
      m1  <= m0;
      flt <= (s1 & m0) | (s1 & m1) | (m0 & m1);
    end
  end

  assign lvl = flt;
`else
  assign lvl = s1;
`endif

  assign rise     = lvl & ~s2;
  assign fall     = ~lvl & s2;
  assign start_ev = cap_start(cfg_mode, rise, fall);
  assign end_ev   = cap_end(cfg_mode, rise, fall);
  assign push     = (state == CAP_COUNT) && end_ev && !setcap;
  assign pop      = rdcap & ~setcap;
  assign cap_busy = (state == CAP_COUNT);

  // Configuration load and IDLE/COUNT measurement machine; setcap overrides everything.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      cfg_pin  <= '0;
      cfg_mode <= CAP_OFF;
      state    <= CAP_IDLE;
      cnt      <= '0;
    end else if (setcap) begin
      cfg_pin  <= data[CAP_PIN_MSB:CAP_PIN_LSB];
      cfg_mode <= data[CAP_MODE_MSB:CAP_MODE_LSB];
      state    <= CAP_IDLE;
      cnt      <= '0;
    end else begin
      case (state)
        CAP_IDLE: begin
          if (start_ev) begin
            state <= CAP_COUNT;
            cnt   <= 32'd1;
          end
        end
        CAP_COUNT: begin
          if (end_ev) begin
            cnt <= 32'd1;
            if (!cap_is_period(cfg_mode)) state <= CAP_IDLE;
          end else if (cnt != CAP_SAT) begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= CAP_IDLE;
      endcase
    end
  end

  cog_cap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk_cog),
    .rst   (res),
    .flush (setcap),
    .push  (push),
    .pop   (pop),
    .din   (cnt),
    .dout  (cap_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .ovf   (cap_ovf)
  );

  assign cap_valid = ~fifo_empty;

endmodule

// File: tb/tb_cog_cap.sv
// tb/tb_cog_cap.sv - scoreboard bench for cog_cap (honours COG_CAP_GLITCH_EN)
module tb_cog_cap;

  logic        clk_cog = 1'b0;
  logic        res;
  logic        setcap;
  logic [31:0] data;
  logic [31:0] pin_in;
  logic        rdcap;
  logic [31:0] cap_data;
  logic        cap_valid;
  logic        cap_ovf;
  logic        cap_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef COG_CAP_GLITCH_EN
  localparam int EV_LAT = 4;
`else
  localparam int EV_LAT = 2;
`endif

  cog_cap #(.FIFO_DEPTH(4)) dut (
    .clk_cog   (clk_cog),
    .res       (res),
    .setcap    (setcap),
    .data      (data),
    .pin_in    (pin_in),
    .rdcap     (rdcap),
    .cap_data  (cap_data),
    .cap_valid (cap_valid),
    .cap_ovf   (cap_ovf),
    .cap_busy  (cap_busy)
  );

  always #5 clk_cog = ~clk_cog;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_cog);
  endtask

  task automatic do_setcap(input logic [2:0] mode, input logic [4:0] pin);
    data = $urandom;
    data[28:26] = mode;
    data[4:0] = pin;
    setcap = 1'b1;
    cyc(1);
    setcap = 1'b0;
  endtask

  task automatic pulse(input int pin, input int hi, input int lo);
    pin_in[pin] = 1'b1;
    cyc(hi);
    pin_in[pin] = 1'b0;
    cyc(lo);
  endtask

  task automatic drain(input string name);
    int guard;
    logic [31:0] exp;
    guard = 0;
    while (cap_valid && guard < 16) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected entry: got %h expected none", name, cap_data);
      end else begin
        exp = exp_q.pop_front();
        if (cap_data !== exp) begin
          errors++;
          $display("FAIL %s entry: got %h expected %h", name, cap_data, exp);
        end
      end
      rdcap = 1'b1;
      cyc(1);
      rdcap = 1'b0;
      guard++;
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s missing entries: got %0d left expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    res = 1'b1; setcap = 1'b0; rdcap = 1'b0; data = '0; pin_in = '0;
    cyc(2);
    checks++; if (cap_data !== 32'h0) begin errors++; $display("FAIL reset cap_data: got %h expected 0", cap_data); end
    checks++; if (cap_valid !== 1'b0) begin errors++; $display("FAIL reset cap_valid: got %b expected 0", cap_valid); end
    checks++; if (cap_ovf !== 1'b0) begin errors++; $display("FAIL reset cap_ovf: got %b expected 0", cap_ovf); end
    checks++; if (cap_busy !== 1'b0) begin errors++; $display("FAIL reset cap_busy: got %b expected 0", cap_busy); end
    res = 1'b0;
    cyc(1);
  endtask

  task automatic test_high_width;
    do_setcap(3'b001, 5'd5);
    cyc(6);
    pin_in[5] = 1'b1;
    cyc(EV_LAT);
    checks++; if (cap_busy !== 1'b0) begin errors++; $display("FAIL high busy_early: got %b expected 0", cap_busy); end
    cyc(1);
    checks++; if (cap_busy !== 1'b1) begin errors++; $display("FAIL high busy_on: got %b expected 1", cap_busy); end
    cyc(10 - EV_LAT - 1);
    pin_in[5] = 1'b0;
    exp_q.push_back(32'd10);
    for (int i = 1; i <= EV_LAT + 1; i++) begin
      cyc(1);
      checks++;
      if (cap_valid !== (i == EV_LAT + 1)) begin
        errors++;
        $display("FAIL high latency cycle %0d: got %b expected %b", i, cap_valid, (i == EV_LAT + 1));
      end
    end
    cyc(2);
    drain("high");
    checks++; if (cap_busy !== 1'b0) begin errors++; $display("FAIL high busy_off: got %b expected 0", cap_busy); end
  endtask

  task automatic test_period;
    int hi_t[3] = '{3, 3, 6};
    int lo_t[3] = '{4, 4, 6};
    int el;
    do_setcap(3'b011, 5'd2);
    cyc(6);
    el = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) exp_q.push_back(hi_t[k-1] + lo_t[k-1]);
      pin_in[2] = 1'b1;
      for (int c = 0; c < hi_t[k] + lo_t[k]; c++) begin
        if (c == hi_t[k]) pin_in[2] = 1'b0;
        cyc(1);
        el++;
        if (el >= EV_LAT + 1) begin
          checks++;
          if (cap_busy !== 1'b1) begin errors++; $display("FAIL period busy at %0d: got %b expected 1", el, cap_busy); end
        end
      end
    end
    exp_q.push_back(32'd12);
    pin_in[2] = 1'b1;
    cyc(EV_LAT + 2);
    drain("period");
    checks++; if (cap_busy !== 1'b1) begin errors++; $display("FAIL period busy_end: got %b expected 1", cap_busy); end
  endtask

  task automatic test_overflow;
    do_setcap(3'b001, 5'd0);
    cyc(6);
    for (int i = 0; i < 4; i++) begin
      pulse(0, 2 + i, 6);
      exp_q.push_back(2 + i);
    end
    checks++; if (cap_ovf !== 1'b0) begin errors++; $display("FAIL ovf filled_no_ovf: got %b expected 0", cap_ovf); end
    checks++; if (cap_data !== 32'd2) begin errors++; $display("FAIL ovf head: got %h expected 2", cap_data); end
    pin_in[0] = 1'b1;
    cyc(7);
    pin_in[0] = 1'b0;
    cyc(EV_LAT);
    checks++;
    if (cap_data !== exp_q[0]) begin errors++; $display("FAIL ovf popped_head: got %h expected %h", cap_data, exp_q[0]); end
    void'(exp_q.pop_front());
    exp_q.push_back(32'd7);
    rdcap = 1'b1;
    cyc(1);
    rdcap = 1'b0;
    cyc(4);
    checks++; if (cap_ovf !== 1'b0) begin errors++; $display("FAIL ovf passthrough: got %b expected 0", cap_ovf); end
    pulse(0, 9, 6);
    checks++; if (cap_ovf !== 1'b1) begin errors++; $display("FAIL ovf set: got %b expected 1", cap_ovf); end
    drain("ovf");
    checks++; if (cap_ovf !== 1'b1) begin errors++; $display("FAIL ovf sticky: got %b expected 1", cap_ovf); end
  endtask

  task automatic test_setcap_midpulse;
    do_setcap(3'b001, 5'd5);
    cyc(6);
    pulse(5, 3, 6);
    pin_in[5] = 1'b1;
    cyc(EV_LAT + 4);
    checks++; if (cap_busy !== 1'b1) begin errors++; $display("FAIL midpulse busy_before: got %b expected 1", cap_busy); end
    do_setcap(3'b001, 5'd5);
    checks++; if (cap_valid !== 1'b0) begin errors++; $display("FAIL midpulse flush_valid: got %b expected 0", cap_valid); end
    checks++; if (cap_data !== 32'h0) begin errors++; $display("FAIL midpulse flush_data: got %h expected 0", cap_data); end
    checks++; if (cap_busy !== 1'b0) begin errors++; $display("FAIL midpulse busy_after: got %b expected 0", cap_busy); end
    cyc(3);
    pin_in[5] = 1'b0;
    cyc(EV_LAT + 4);
    checks++; if (cap_valid !== 1'b0) begin errors++; $display("FAIL midpulse partial_captured: got %b expected 0", cap_valid); end
    pulse(5, 4, 6);
    exp_q.push_back(32'd4);
    drain("midpulse");
  endtask

  task automatic test_saturation;
    pin_in[5] = 1'b1;
    cyc(EV_LAT + 2);
    force dut.cnt = 32'hFFFF_FFFE;
    cyc(1);
    release dut.cnt;
    cyc(4);
    pin_in[5] = 1'b0;
    exp_q.push_back(32'hFFFF_FFFF);
    cyc(EV_LAT + 3);
    drain("sat");
  endtask

  task automatic test_reset_midcount;
    do_setcap(3'b001, 5'd5);
    cyc(6);
    pulse(5, 3, 6);
    pulse(5, 5, 6);
    pin_in[5] = 1'b1;
    cyc(EV_LAT + 2);
    checks++; if (cap_busy !== 1'b1) begin errors++; $display("FAIL rstmid busy_before: got %b expected 1", cap_busy); end
    checks++; if (cap_valid !== 1'b1) begin errors++; $display("FAIL rstmid valid_before: got %b expected 1", cap_valid); end
    #2 res = 1'b1;
    #1;
    checks++;
    if ({cap_data, cap_valid, cap_ovf, cap_busy} !== 35'h0) begin
      errors++;
      $display("FAIL rstmid outputs: got data=%h v=%b o=%b b=%b expected all 0", cap_data, cap_valid, cap_ovf, cap_busy);
    end
    cyc(1);
    res = 1'b0;
    cyc(2);
    pin_in[5] = 1'b0;
    cyc(3);
    pulse(5, 4, 6);
    checks++; if (cap_valid !== 1'b0) begin errors++; $display("FAIL rstmid no_capture: got %b expected 0", cap_valid); end
    checks++; if (cap_busy !== 1'b0) begin errors++; $display("FAIL rstmid no_busy: got %b expected 0", cap_busy); end
    do_setcap(3'b001, 5'd5);
    cyc(6);
    pulse(5, 3, 6);
    exp_q.push_back(32'd3);
    drain("rstmid");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_high_width();
    test_period();
    test_overflow();
    test_setcap_midpulse();
    test_saturation();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cog_cap.md
# cog_cap

Per-cog input-capture unit: the measuring counterpart to the cog counter's waveform generators. It times pulse widths or periods on one selected pin and queues the results in a small FIFO that the cog drains. The block sits beside the cog counters. It takes the same `pin_in` bus and the same cog write-data path, and it returns capture words to the cog's source-operand mux.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: capture queue depth; must be a power of 2, minimum 2.

Ports:
- `clk_cog` in 1: cog clock; all logic is on its rising edge.
- `res` in 1: asynchronous, active-high reset.
- `setcap` in 1: one-cycle strobe that loads the configuration from `data`.
- `data` in 32: configuration word. Bits [4:0] select the pin; bits [28:26] select the mode; all other bits are ignored.
- `pin_in` in 32: raw, asynchronous pin levels.
- `rdcap` in 1: one-cycle pop strobe.
- `cap_data` out 32: FIFO head; 0 when the FIFO is empty.
- `cap_valid` out 1: FIFO not empty.
- `cap_ovf` out 1: sticky overflow flag.
- `cap_busy` out 1: a measurement is in progress (the unit is armed and counting).

## Operation
- Modes (`cfg[28:26]`):
  - 000: off.
  - 001: high width, rise to fall.
  - 010: low width, fall to rise.
  - 011: period, rise to rise.
  - 100: period, fall to fall.
  - 101 to 111: off.
- Input path:
  - The selected pin goes through 2 synchronizer flops, `s0` then `s1`, followed by a history flop `s2`.
  - Rise event = `s1 & ~s2`; fall event = `~s1 & s2`.
- Start event and end event per mode:
  - 001: start on rise, end on fall.
  - 010: start on fall, end on rise.
  - 011: start and end are both rise.
  - 100: start and end are both fall.
- States:
  - IDLE: waiting for a start event.
  - COUNT: measuring.
  - Off modes hold IDLE.
- IDLE to COUNT: on a start event, `cnt <= 1`.
- In COUNT, each cycle without an end event: `cnt <= cnt + 1`, saturating at 0xFFFFFFFF (no wrap).
- End event in COUNT:
  - Push `cnt` into the FIFO.
  - Width modes return to IDLE.
  - Period modes stay in COUNT with `cnt <= 1`, because the end edge is also the next start.
- Result: a pin level held for exactly N `clk_cog` samples captures the value N.
- The first start event after `setcap` arms the unit, so partial pulses already in progress are never captured.
- `setcap`:
  - Loads the configuration.
  - Forces IDLE and clears `cnt`.
  - Flushes the FIFO and clears `cap_ovf`.
  - Has priority over any same-cycle event or pop; the event and the pop are discarded.
- FIFO:
  - `rdcap` while empty is ignored.
  - A push while full with no pop drops the new word and sets `cap_ovf`.
  - A push and a pop in the same cycle while full both succeed, and `cap_ovf` is not set.
  - A push and a pop in the same cycle while empty leave the pushed word valid on the next cycle.
- Reset: IDLE, mode off, `cnt` = 0, FIFO empty, `s0`/`s1`/`s2` = 0, and all outputs = 0.

## Timing
- Pin edge to event detect: 2 cycles. The edge is registered in `s0`, then in `s1`, and the event is visible combinationally in the cycle where `s1 != s2`.
- End event to `cap_valid` high: 1 cycle (registered push). A pin edge at cycle t gives `cap_valid` at t+3.
- `rdcap` at cycle t: `cap_data` shows the next entry, or `cap_valid` deasserts, at t+1.
- `setcap` at cycle t: the new configuration is active at t+1. Edges already in the synchronizer are evaluated under the new mode, but only a start edge can act, because the unit is IDLE.
- `cap_busy` is registered and is high exactly in COUNT.
- The minimum measurable width is 1 cycle. Pulses shorter than one `clk_cog` period may be missed.

## Configuration
- `COG_CAP_GLITCH_EN`:
  - Defined: a 3-sample majority filter follows `s1`, and edge detection uses the filtered level. Single-cycle glitches are rejected, and pin-to-event latency grows by 2 cycles (edge at t gives `cap_valid` at t+5).
  - Undefined: no filter, and the latencies above apply.
  - Captured widths equal the pin-level durations in both builds.

## Structure
- Shared package `cog_pkg`: mode encodings (`CAP_OFF`, `CAP_HIGH`, `CAP_LOW`, `CAP_PER_R`, `CAP_PER_F`), configuration field positions (`CAP_PIN_LSB`/`MSB`, `CAP_MODE_LSB`/`MSB`), and `CAP_SAT` = 32'hFFFFFFFF.
- Sub-module `cog_cap_fifo`: a synchronous FIFO with flush, with push/pop/full/empty and the full-with-pop pass-through rule above. The remainder stays in `cog_cap`.

## Test plan
- Mode 001 on pin 5; pin 5 high for 10 cycles, then low → one entry = 10; `cap_valid` rises 3 cycles after the falling edge (5 cycles with `COG_CAP_GLITCH_EN`).
- Mode 011; rising edges spaced 7, 7, then 12 cycles → entries 7, 7, 12 in order; `cap_busy` stays high throughout.
- `FIFO_DEPTH`=4; 5 captures with no reads → 4 entries kept (the first 4), `cap_ovf`=1. Then a capture with a same-cycle `rdcap` while full → no loss.
- `setcap` issued while the pin is already high in mode 001 → the ongoing pulse is not captured; the next full pulse of 4 cycles → entry = 4.
- Force `cnt` near saturation (hold the pin high for more than 2^32 cycles in a shortened-counter simulation build, or force `cnt`=32'hFFFFFFFE) → entry = 32'hFFFFFFFF; no wrap.
- Assert `res` mid-COUNT with 2 entries queued → all outputs are 0 immediately; no capture occurs after reset until `setcap` plus a start edge.
